packed_net_ctrl: RTL and testbench
==================================

# packed_net_ctrl

Sequencing and configuration controller for a multi-stage packed switch network. Each stage holds SWITCH_SIZE 2x2 switches with a one-cycle registered data path. The block stores per-stage switch-setting patterns and accepts permutation jobs (pattern id, beat count). It paces data beats into stage 0 and presents each stage's SWITCH_SET skewed so that every beat sees its own pattern at every stage. It sits between the job scheduler and the network stage instances.

## Interface
- PORT_SIZE, 32, ports per stage
- SWITCH_SIZE, PORT_SIZE/2, switches per stage
- NUM_STAGES, 9, stages in the network (2*log2(PORT_SIZE)-1)
- NUM_PATTERNS, 4, stored permutation patterns
- BEAT_W, 16, width of job beat count
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  pattern-table write strobe
- cfg_pat  in  $clog2(NUM_PATTERNS)  pattern index for write
- cfg_stage  in  $clog2(NUM_STAGES)  stage index for write
- cfg_data  in  SWITCH_SIZE  switch bits for that pattern/stage
- cfg_err  out  1  one-cycle pulse: rejected write
- start_valid  in  1  job request
- start_ready  out  1  job accepted when start_valid && start_ready
- start_pat  in  $clog2(NUM_PATTERNS)  job pattern id
- start_beats  in  BEAT_W  number of beats in job
- src_valid  in  1  upstream beat available
- src_ready  out  1  beat consumed when src_valid && src_ready
- net_in_valid  out  1  beat entering stage 0 this cycle
- net_out_valid  out  1  beat leaving final stage this cycle
- SWITCH_SET  out  NUM_STAGES*SWITCH_SIZE  stage k uses bits [k*SWITCH_SIZE +: SWITCH_SIZE]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion

## Operation
- Pattern table: NUM_PATTERNS x NUM_STAGES x SWITCH_SIZE registers. Reset clears all entries to 0, which is pass-through.
- Config writes: a write is accepted only in IDLE with cfg_stage < NUM_STAGES. The entry updates on the next edge. Any other cfg_we is ignored, and cfg_err pulses one cycle later.
- FSM states:
  - IDLE
    - start_ready=1.
    - On start accept: latch the pattern id and beat count.
    - Beat count 0: go to DONE.
    - Otherwise: go to RUN.
  - RUN
    - src_ready=1 and net_in_valid = src_valid.
    - Each accepted beat decrements the remaining count.
    - On the last accepted beat: go to DRAIN and load the drain counter with NUM_STAGES-1.
  - DRAIN
    - src_ready=0.
    - Decrement the drain counter each cycle.
    - At 0: go to DONE.
  - DONE
    - done=1 for one cycle, then go to IDLE.
- Skew pipeline: registers vld[1..NUM_STAGES] and pid[1..NUM_STAGES-1].
  - Stage 0 inputs: vld[0]=net_in_valid and pid[0]=latched pattern (combinational).
  - Each cycle: vld[k+1]<=vld[k] and pid[k+1]<=pid[k].
- SWITCH_SET for stage k = vld[k] ? table[pid[k]][k] : 0. The stage value is 0 when no beat is present.
- net_out_valid = vld[NUM_STAGES].
- Bubbles (src_valid low in RUN) propagate as vld=0 and are not counted.
- Reset mid-operation: the FSM returns to IDLE and all vld/pid and table registers clear. No done pulse is issued. Data already in the network is discarded.

## Timing
- Reset values: start_ready=1, src_ready=0, net_in_valid=0, net_out_valid=0, SWITCH_SET=0, busy=0, done=0, cfg_err=0.
- Job start: accepted at edge t. RUN is active in cycle t+1, so the first beat can be consumed at t+1.
- Latency: a beat consumed at cycle c has SWITCH_SET of stage k driven with its pattern during cycle c+k. net_out_valid is high in cycle c+NUM_STAGES.
- Completion: the last beat is consumed at cycle L. done is high in cycle L+NUM_STAGES, the same cycle as that beat's net_out_valid. The FSM is back in IDLE at L+NUM_STAGES+1.
- Zero-beat job: accepted at t, done in cycle t+1, IDLE at t+2.
- Full throughput: with src_valid held high, one beat per cycle and no bubbles.
- start_valid in any non-IDLE state is not accepted and is held off by start_ready=0.
- cfg_we and start_valid in the same IDLE cycle: both are accepted. The job uses the table as updated by that write.

## Test plan
- Pattern 1, stage 3 written to 16'hA5A5, then a 1-beat job on pattern 1 with the beat at cycle c:
  - SWITCH_SET[3*16 +:16]=16'hA5A5 only in cycle c+3.
  - All other stages are 0 except in their own cycle c+k.
  - net_out_valid at c+9; done at c+9.
- 8-beat job on pattern 2 with src_valid held high:
  - 8 consecutive net_out_valid cycles.
  - Every stage k shows table[2][k] for 8 consecutive cycles starting at first-beat+k.
  - done coincides with the 8th net_out_valid.
- 4-beat job with src_valid toggling 1,0,1,0,...:
  - 4 beats are counted and the bubbles appear as gaps in net_out_valid.
  - SWITCH_SET is 0 in bubble slots.
- cfg_we during RUN, and cfg_we with cfg_stage=9 in IDLE:
  - cfg_err pulses one cycle later in each case.
  - The table is unchanged, read back via a subsequent job.
- start_beats=0: done one cycle after acceptance; net_in_valid never asserts.
- rst_n asserted in the middle of an 8-beat job after 3 beats:
  - All outputs return to reset values immediately; no done pulse.
  - The table reads back 0 on a following job.

Source files
------------

// File: rtl/packed_net_ctrl.sv
// Sequencing/configuration controller for a multi-stage packed switch network:
// stores per-stage switch patterns, paces job beats and skews SWITCH_SET per stage.
module packed_net_ctrl #(
  parameter int unsigned PORT_SIZE    = 32,
  parameter int unsigned SWITCH_SIZE  = PORT_SIZE / 2,
  parameter int unsigned NUM_STAGES   = 9,
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned BEAT_W       = 16,
  localparam int unsigned PW = $clog2(NUM_PATTERNS),
  localparam int unsigned SW = $clog2(NUM_STAGES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [PW-1:0]                     cfg_pat,
  input  logic [SW-1:0]                     cfg_stage,
  input  logic [SWITCH_SIZE-1:0]            cfg_data,
  output logic                              cfg_err,
  input  logic                              start_valid,
  output logic                              start_ready,
  input  logic [PW-1:0]                     start_pat,
  input  logic [BEAT_W-1:0]                 start_beats,
  input  logic                              src_valid,
  output logic                              src_ready,
  output logic                              net_in_valid,
  output logic                              net_out_valid,
  output logic [NUM_STAGES*SWITCH_SIZE-1:0] SWITCH_SET,
  output logic                              busy,
  output logic                              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [SW-1:0] LastStage = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] DrainLoad = SW'(NUM_STAGES - 1);

  state_e                 state_q;
  logic [PW-1:0]          pat_q;
  logic [BEAT_W-1:0]      rem_q;
  logic [SW-1:0]          drain_q;

  logic [SWITCH_SIZE-1:0] tbl_q [NUM_PATTERNS][NUM_STAGES];
  logic                   cfg_ok;
  logic                   cfg_err_q;

  logic [NUM_STAGES:0]    vld;
  logic [PW-1:0]          pid   [NUM_STAGES];
  logic [NUM_STAGES:1]    vld_q;
  logic [PW-1:0]          pid_q [1:NUM_STAGES-1];

  // Job FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pat_q   <= '0;
      rem_q   <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            pat_q   <= start_pat;
            rem_q   <= start_beats;
            state_q <= (start_beats == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (src_valid) begin
            rem_q <= rem_q - BEAT_W'(1);
            if (rem_q == BEAT_W'(1)) begin
              drain_q <= DrainLoad;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q - SW'(1);
          // Leave one count early so DONE lines up with the last beat exiting.
          if (drain_q <= SW'(1)) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready  = (state_q == StIdle);
  assign src_ready    = (state_q == StRun);
  assign net_in_valid = src_ready & src_valid;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

  // Pattern table; writes only land while idle so a running job never sees a change.
  assign cfg_ok = cfg_we && (state_q == StIdle) && (cfg_stage <= LastStage);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
      for (int p = 0; p < int'(NUM_PATTERNS); p++) begin
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
          tbl_q[p][s] <= '0;
        end
      end
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      for (int p = 0; p < int'(NUM_PATTERNS); p++) begin
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
          if (cfg_ok && (cfg_pat == PW'(p)) && (cfg_stage == SW'(s))) begin
            tbl_q[p][s] <= cfg_data;
          end
        end
      end
    end
  end

  assign cfg_err = cfg_err_q;

  // Skew pipeline: each beat carries its pattern id alongside the stage data path.
  assign vld = {vld_q, net_in_valid};

  always_comb begin
    pid[0] = pat_q;
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      pid[k] = pid_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        pid_q[k] <= '0;
      end
    end else begin
      vld_q <= vld[NUM_STAGES-1:0];
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        pid_q[k] <= pid[k-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    assign SWITCH_SET[k*SWITCH_SIZE +: SWITCH_SIZE] = vld[k] ? tbl_q[pid[k]][k] : '0;
  end

  assign net_out_valid = vld[NUM_STAGES];

endmodule

// File: tb/tb_packed_net_ctrl.sv
// Randomised scoreboard bench for packed_net_ctrl against a cycle-indexed
// reference model of expected stage settings and output events.
module tb_packed_net_ctrl;
  localparam int NS   = 9;
  localparam int SWS  = 16;
  localparam int NP   = 4;
  localparam int W    = NS * SWS;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_pat = '0;
  logic [3:0]    cfg_stage = '0;
  logic [15:0]   cfg_data = '0;
  logic          cfg_err;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [1:0]    start_pat = '0;
  logic [15:0]   start_beats = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic          net_in_valid;
  logic          net_out_valid;
  logic [W-1:0]  switch_set;
  logic          busy;
  logic          done;

  packed_net_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_pat      (cfg_pat),
    .cfg_stage    (cfg_stage),
    .cfg_data     (cfg_data),
    .cfg_err      (cfg_err),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_pat    (start_pat),
    .start_beats  (start_beats),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .net_in_valid (net_in_valid),
    .net_out_valid(net_out_valid),
    .SWITCH_SET   (switch_set),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: table contents and per-cycle expectations.
  logic [15:0]  mtab [NP][NS];
  logic [W-1:0] exp_sw [MAXC];
  bit           exp_niv [MAXC];
  bit           exp_busy [MAXC];
  int           evq [3][$];  // expected cycles of net_out_valid, done, cfg_err
  string        nm [3] = '{"net_out_valid", "done", "cfg_err"};
  logic         seen [3];
  bit           mon_en = 1'b0;

  bit           pre_cfg = 1'b0;
  int           pre_p, pre_s;
  logic [15:0]  pre_d;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int from);
    for (int i = from; i < MAXC; i++) begin
      exp_sw[i]   = '0;
      exp_niv[i]  = 1'b0;
      exp_busy[i] = 1'b0;
    end
  endtask

  task automatic clear_tab();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NS; k++) mtab[p][k] = '0;
  endtask

  task automatic rec_beat(input int c, input int p);
    exp_niv[c] = 1'b1;
    for (int k = 0; k < NS; k++) exp_sw[c+k][k*SWS +: SWS] = mtab[p][k];
    evq[0].push_back(c + NS);
  endtask

  task automatic cfg_drive(input int p, input int s, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_pat   = 2'(p);
    cfg_stage = 4'(s);
    cfg_data  = d;
    if (!exp_busy[cyc] && s < NS) mtab[p][s] = d;
    else evq[2].push_back(cyc + 1);
  endtask

  task automatic cfg(input int p, input int s, input logic [15:0] d);
    cfg_drive(p, s, d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rst_chk();
    chk("rst start_ready", W'(start_ready), W'(1));
    chk("rst src_ready", W'(src_ready), W'(0));
    chk("rst net_in_valid", W'(net_in_valid), W'(0));
    chk("rst net_out_valid", W'(net_out_valid), W'(0));
    chk("rst switch_set", switch_set, W'(0));
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst cfg_err", W'(cfg_err), W'(0));
  endtask

  // mode: 0 src_valid held high, 1 toggling from 1, 2 random
  task automatic run_job(input int pat, input int beats, input int mode, input bit mid_cfg);
    int cnt = 0, last = 0, budget = 0;
    bit v, tog = 1'b1;
    start_valid = 1'b1;
    start_pat   = 2'(pat);
    start_beats = 16'(beats);
    if (beats == 0) src_valid = 1'b1;
    if (pre_cfg) begin
      cfg_drive(pre_p, pre_s, pre_d);
      pre_cfg = 1'b0;
    end
    step();
    start_valid = 1'b0;
    cfg_we      = 1'b0;
    if (beats == 0) begin
      exp_busy[cyc] = 1'b1;
      evq[1].push_back(cyc);
      step();
      src_valid = 1'b0;
      return;
    end
    while (cnt < beats && budget < 400) begin
      exp_busy[cyc] = 1'b1;
      if (mid_cfg && budget == 0) cfg_drive(pat, 0, ~mtab[pat][0]);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      src_valid = v;
      if (v) begin
        rec_beat(cyc, pat);
        cnt++;
        last = cyc;
      end
      step();
      cfg_we = 1'b0;
      budget++;
    end
    src_valid = 1'b0;
    if (cnt < beats) begin
      n_chk++;
      n_err++;
      $display("FAIL job_budget: got %0d beats expected %0d", cnt, beats);
    end
    for (int x = last + 1; x <= last + NS; x++) exp_busy[x] = 1'b1;
    evq[1].push_back(last + NS);
    while (cyc < last + NS + 1) step();
  endtask

  // Monitor: per-cycle stage settings plus event scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      seen[0] = net_out_valid;
      seen[1] = done;
      seen[2] = cfg_err;
      chk("switch_set", switch_set, exp_sw[cyc]);
      chk("net_in_valid", W'(net_in_valid), W'(exp_niv[cyc]));
      chk("busy", W'(busy), W'(exp_busy[cyc]));
      chk("start_ready", W'(start_ready), W'(!exp_busy[cyc]));
      for (int i = 0; i < 3; i++) begin
        while (evq[i].size() > 0 && evq[i][0] < cyc) begin
          n_chk++;
          n_err++;
          $display("FAIL %s missing: got none expected at cycle %0d", nm[i], evq[i][0]);
          void'(evq[i].pop_front());
        end
        if (seen[i]) begin
          n_chk++;
          if (evq[i].size() > 0 && evq[i][0] == cyc) void'(evq[i].pop_front());
          else begin
            n_err++;
            $display("FAIL %s unexpected: got pulse at cycle %0d expected none", nm[i], cyc);
          end
        end
      end
    end
  end

  initial begin
    flush(0);
    clear_tab();
    #1 rst_n = 1'b0;
    #1 rst_chk();
    mon_en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single beat on a single written entry
    cfg(1, 3, 16'hA5A5);
    run_job(1, 1, 0, 1'b0);

    // Full-throughput 8-beat job on a fully written pattern
    for (int k = 0; k < NS; k++) cfg(2, k, 16'($urandom));
    run_job(2, 8, 0, 1'b0);

    // Bubbles
    run_job(2, 4, 1, 1'b0);

    // Rejected writes: during RUN and with an out-of-range stage
    cfg(3, 1, 16'h0F0F);
    run_job(3, 5, 0, 1'b1);
    cfg(3, 9, 16'hFFFF);
    run_job(3, 2, 0, 1'b0);

    // Write and start in the same idle cycle
    pre_cfg = 1'b1; pre_p = 0; pre_s = 5; pre_d = 16'h1234;
    run_job(0, 3, 2, 1'b0);

    // Zero-beat job with src_valid high throughout
    run_job(1, 0, 0, 1'b0);

    // Reset in the middle of an 8-beat job after 3 beats
    start_valid = 1'b1; start_pat = 2'd2; start_beats = 16'd8;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_busy[cyc] = 1'b1;
      src_valid = 1'b1;
      rec_beat(cyc, 2);
      step();
    end
    src_valid = 1'b0;
    rst_n = 1'b0;
    flush(cyc);
    for (int i = 0; i < 3; i++) evq[i].delete();
    clear_tab();
    #1 rst_chk();
    step();
    step();
    rst_n = 1'b1;
    step();
    run_job(1, 1, 0, 1'b0);
    run_job(2, 3, 0, 1'b0);

    // Randomised traffic
    repeat (25) begin
      if ($urandom_range(0, 1) == 1)
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 16'($urandom));
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
    end

    repeat (3) step();
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (evq[i].size() != 0) begin
        n_err++;
        $display("FAIL %s leftover: got %0d pending expected 0", nm[i], evq[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
